// File: rtl/uart_dbg_arbiter_if.sv
// Handshake bundle between the debug-message requesters, the UART debug channel
// and uart_dbg_arbiter. req_data packs source i at bits [8i+7:8i].
interface uart_dbg_arbiter_if #(
    parameter int NUM_SRC = 4
);
    localparam int SRC_W = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0]          req_valid;
    logic [NUM_SRC-1:0][7:0]     req_data;
    logic [NUM_SRC-1:0]          req_last;
    logic [NUM_SRC-1:0]          req_ready;
    logic                        dbg_wr;
    logic [7:0]                  dbg_msg;
    logic                        dbg_full;
    logic [NUM_SRC-1:0]          grant;
    logic [SRC_W-1:0]            active_src;
    logic                        timeout_pulse;

    // Requesters and channel side.
    modport master (
        output req_valid, req_data, req_last, dbg_full,
        input  req_ready, dbg_wr, dbg_msg, grant, active_src, timeout_pulse
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_data, req_last, dbg_full,
        output req_ready, dbg_wr, dbg_msg, grant, active_src, timeout_pulse
    );
endinterface

// File: rtl/uart_dbg_arbiter.sv
// Round-robin whole-message arbiter for the shared UART debug channel, with stall timeout.
// Optional tag byte (8'hA0 | source) before each message when UART_DBG_ARB_SRC_TAG_EN is defined.
module uart_dbg_arbiter #(
    parameter int NUM_SRC        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    uart_dbg_arbiter_if.slave bus
);
    localparam int SRC_W = $clog2(NUM_SRC);
    localparam int IDX_W = SRC_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

`ifdef UART_DBG_ARB_SRC_TAG_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_STREAM = 2'd1, S_TAG = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_STREAM = 2'd1} state_t;
`endif

    state_t             state_q, state_n;
    logic [NUM_SRC-1:0] grant_q, grant_n;
    logic [SRC_W-1:0]   src_q, src_n;
    logic [SRC_W-1:0]   rr_q, rr_n;
    logic [TMR_W-1:0]   tmr_q, tmr_n;
    logic [SRC_W-1:0]   pick;
    logic [IDX_W-1:0]   idx;
    logic [SRC_W-1:0]   src_next;
    logic               g_valid, g_last, xfer, tmo;
    logic [NUM_SRC-1:0] ready;
    logic               wr;
    logic [7:0]         msg;

    // First valid source at or after rr_q, wrapping by compare so non-power-of-2 counts work.
    always_comb begin
        pick = '0;
        idx  = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            idx = IDX_W'(rr_q) + IDX_W'(k);
            if (idx >= IDX_W'(NUM_SRC))
                idx = idx - IDX_W'(NUM_SRC);
            if (bus.req_valid[idx[SRC_W-1:0]])
                pick = idx[SRC_W-1:0];
        end
    end

    assign src_next = (src_q == SRC_W'(NUM_SRC - 1)) ? '0 : src_q + 1'b1;
    assign g_valid  = bus.req_valid[src_q];
    assign g_last   = bus.req_last[src_q];

    always_comb begin
        state_n = state_q;
        grant_n = grant_q;
        src_n   = src_q;
        rr_n    = rr_q;
        tmr_n   = tmr_q;
        ready   = '0;
        wr      = 1'b0;
        xfer    = 1'b0;
        tmo     = 1'b0;
        msg     = bus.req_data[src_q];
        case (state_q)
            S_IDLE: begin
                if (|bus.req_valid) begin
                    grant_n       = '0;
                    grant_n[pick] = 1'b1;
                    src_n         = pick;
                    tmr_n         = '0;
`ifdef UART_DBG_ARB_SRC_TAG_EN
                    state_n       = S_TAG;
`else
                    state_n       = S_STREAM;
`endif
                end
            end
`ifdef UART_DBG_ARB_SRC_TAG_EN
            S_TAG: begin
                msg = 8'hA0 | 8'(src_q);
                wr  = !bus.dbg_full;
                if (!bus.dbg_full) begin
                    state_n = S_STREAM;
                    tmr_n   = '0;
                end
            end
`endif
            S_STREAM: begin
                ready[src_q] = !bus.dbg_full;
                xfer         = g_valid && !bus.dbg_full;
                wr           = xfer;
                if (xfer) begin
                    tmr_n = '0;
                    if (g_last) begin
                        state_n = S_IDLE;
                        grant_n = '0;
                        rr_n    = src_next;
                    end
                end else if (!g_valid && !bus.dbg_full) begin
                    // Only starvation counts; a full channel holds the timer.
                    if (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                        tmo     = 1'b1;
                        state_n = S_IDLE;
                        grant_n = '0;
                        rr_n    = src_next;
                        tmr_n   = '0;
                    end else begin
                        tmr_n = tmr_q + 1'b1;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            src_q   <= '0;
            rr_q    <= '0;
            tmr_q   <= '0;
        end else begin
            state_q <= state_n;
            grant_q <= grant_n;
            src_q   <= src_n;
            rr_q    <= rr_n;
            tmr_q   <= tmr_n;
        end
    end

    assign bus.req_ready     = ready;
    assign bus.dbg_wr        = wr;
    assign bus.dbg_msg       = msg;
    assign bus.grant         = grant_q;
    assign bus.active_src    = src_q;
    assign bus.timeout_pulse = tmo;
endmodule

// File: tb/tb_uart_dbg_arbiter.sv
// Directed bench for uart_dbg_arbiter (NUM_SRC=4, TIMEOUT_CYCLES=8): per-cycle vector table
// plus hand-written reset, round-robin and tag sequences.
module tb_uart_dbg_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    uart_dbg_arbiter_if #(.NUM_SRC(4)) bus ();

    uart_dbg_arbiter #(.NUM_SRC(4), .TIMEOUT_CYCLES(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [31:0] data;
        logic        full;
        logic        wr;
        logic [7:0]  msg;
        logic [3:0]  ready;
        logic [3:0]  grant;
        logic        tmo;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic [3:0] valid, logic [3:0] last, logic [31:0] data,
                               logic full, logic wr, logic [7:0] msg,
                               logic [3:0] ready, logic [3:0] grant, logic tmo);
        vec_t r;
        r.valid = valid; r.last = last; r.data = data; r.full = full;
        r.wr = wr; r.msg = msg; r.ready = ready; r.grant = grant; r.tmo = tmo;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] valid, input logic [3:0] last,
                         input logic [31:0] data, input logic full);
        bus.req_valid = valid;
        bus.req_last  = last;
        bus.req_data  = data;
        bus.dbg_full  = full;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(4'h0, 4'h0, 32'h0, 1'b0);
        tick();
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state with every source asking: nothing may move.
        drive(4'hF, 4'h0, 32'h4433_2211, 1'b0);
        tick();
        tick();
        chk("rst_wr",    bus.dbg_wr,        1'b0);
        chk("rst_ready", bus.req_ready,     4'h0);
        chk("rst_grant", bus.grant,         4'h0);
        chk("rst_src",   bus.active_src,    2'd0);
        chk("rst_tmo",   bus.timeout_pulse, 1'b0);
        drive(4'h0, 4'h0, 32'h0, 1'b0);
        reset = 1'b1;
        tick();

`ifndef UART_DBG_ARB_SRC_TAG_EN
        // Source 1 message 11,22,33; then rr_ptr=2 picks 2 over 1, then 1 after 2.
        tbl.push_back(v(4'b0010, 4'b0000, 32'h0000_1100, 0, 0, 8'h00, 4'b0000, 4'b0000, 0));
        tbl.push_back(v(4'b0010, 4'b0000, 32'h0000_1100, 0, 1, 8'h11, 4'b0010, 4'b0010, 0));
        tbl.push_back(v(4'b0010, 4'b0000, 32'h0000_2200, 0, 1, 8'h22, 4'b0010, 4'b0010, 0));
        tbl.push_back(v(4'b0010, 4'b0010, 32'h0000_3300, 0, 1, 8'h33, 4'b0010, 4'b0010, 0));
        tbl.push_back(v(4'b0000, 4'b0000, 32'h0000_0000, 0, 0, 8'h00, 4'b0000, 4'b0000, 0));
        tbl.push_back(v(4'b0110, 4'b0100, 32'h00B1_AA00, 0, 0, 8'h00, 4'b0000, 4'b0000, 0));
        tbl.push_back(v(4'b0110, 4'b0100, 32'h00B1_AA00, 0, 1, 8'hB1, 4'b0100, 4'b0100, 0));
        tbl.push_back(v(4'b0010, 4'b0010, 32'h0000_AA00, 0, 0, 8'h00, 4'b0000, 4'b0000, 0));
        tbl.push_back(v(4'b0010, 4'b0010, 32'h0000_AA00, 0, 1, 8'hAA, 4'b0010, 4'b0010, 0));
        tbl.push_back(v(4'b0000, 4'b0000, 32'h0000_0000, 0, 0, 8'h00, 4'b0000, 4'b0000, 0));
        // Source 0 with a 10-cycle full stall mid-message.
        tbl.push_back(v(4'b0001, 4'b0000, 32'h0000_0001, 0, 0, 8'h00, 4'b0000, 4'b0000, 0));
        tbl.push_back(v(4'b0001, 4'b0000, 32'h0000_0001, 0, 1, 8'h01, 4'b0001, 4'b0001, 0));
        for (int i = 0; i < 10; i++)
            tbl.push_back(v(4'b0001, 4'b0000, 32'h0000_0002, 1, 0, 8'h00, 4'b0000, 4'b0001, 0));
        tbl.push_back(v(4'b0001, 4'b0000, 32'h0000_0002, 0, 1, 8'h02, 4'b0001, 4'b0001, 0));
        tbl.push_back(v(4'b0001, 4'b0001, 32'h0000_0003, 0, 1, 8'h03, 4'b0001, 4'b0001, 0));
        // Source 2 sends one byte then starves; a full cycle in between holds the timer.
        tbl.push_back(v(4'b1100, 4'b1000, 32'hD1C1_0000, 0, 0, 8'h00, 4'b0000, 4'b0000, 0));
        tbl.push_back(v(4'b1100, 4'b1000, 32'hD1C1_0000, 0, 1, 8'hC1, 4'b0100, 4'b0100, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(v(4'b1000, 4'b1000, 32'hD100_0000, 0, 0, 8'h00, 4'b0100, 4'b0100, 0));
        tbl.push_back(v(4'b1000, 4'b1000, 32'hD100_0000, 1, 0, 8'h00, 4'b0000, 4'b0100, 0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(v(4'b1000, 4'b1000, 32'hD100_0000, 0, 0, 8'h00, 4'b0100, 4'b0100, 0));
        tbl.push_back(v(4'b1000, 4'b1000, 32'hD100_0000, 0, 0, 8'h00, 4'b0100, 4'b0100, 1));
        tbl.push_back(v(4'b1000, 4'b1000, 32'hD100_0000, 0, 0, 8'h00, 4'b0000, 4'b0000, 0));
        tbl.push_back(v(4'b1000, 4'b1000, 32'hD100_0000, 0, 1, 8'hD1, 4'b1000, 4'b1000, 0));
        tbl.push_back(v(4'b0000, 4'b0000, 32'h0000_0000, 0, 0, 8'h00, 4'b0000, 4'b0000, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].valid, tbl[i].last, tbl[i].data, tbl[i].full);
            #1;
            chk($sformatf("v%0d_wr", i),    bus.dbg_wr,        tbl[i].wr);
            if (tbl[i].wr)
                chk($sformatf("v%0d_msg", i), bus.dbg_msg, tbl[i].msg);
            chk($sformatf("v%0d_ready", i), bus.req_ready,     tbl[i].ready);
            chk($sformatf("v%0d_grant", i), bus.grant,         tbl[i].grant);
            chk($sformatf("v%0d_tmo", i),   bus.timeout_pulse, tbl[i].tmo);
            tick();
        end

        // Reset mid-message: source 2 moves rr_ptr to 3, source 1 then streams.
        drive(4'b0100, 4'b0100, 32'h00E2_0000, 1'b0);
        tick();
        tick();
        drive(4'b0010, 4'b0000, 32'h0000_E100, 1'b0);
        tick();
        #1;
        chk("mid_grant", bus.grant, 4'b0010);
        chk("mid_wr",    bus.dbg_wr, 1'b1);
        reset = 1'b0;
        #1;
        chk("arst_wr",    bus.dbg_wr,    1'b0);
        chk("arst_ready", bus.req_ready, 4'h0);
        chk("arst_grant", bus.grant,     4'h0);
        tick();
        reset = 1'b1;
        drive(4'b1011, 4'b1011, 32'h3300_1100, 1'b0);
        #1;
        chk("rel_grant_idle", bus.grant, 4'h0);
        tick();
        chk("rel_grant", bus.grant,      4'b0001);
        chk("rel_src",   bus.active_src, 2'd0);

        // All four sources stream 2-byte messages continuously from reset.
        do_reset();
        begin
            int         order[5] = '{0, 1, 2, 3, 0};
            int         ngr  = 0;
            int         nmsg = 0;
            int         cur  = 0;
            int         bidx = 0;
            logic [3:0] cnt    = 4'h0;
            logic [3:0] prev_g = 4'h0;
            logic [3:0] hs;
            for (int cyc = 0; cyc < 80 && nmsg < 5; cyc++) begin
                bus.req_valid = 4'hF;
                bus.dbg_full  = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    bus.req_data[i] = {4'(i), 3'b000, cnt[i]};
                    bus.req_last[i] = cnt[i];
                end
                #1;
                if (bus.grant != 4'h0 && bus.grant != prev_g) begin
                    if (ngr < 5) begin
                        chk($sformatf("rr_grant%0d", ngr), bus.grant, 4'b0001 << order[ngr]);
                        cur = order[ngr];
                    end
                    ngr++;
                    bidx = 0;
                end
                if (bus.dbg_wr) begin
                    chk($sformatf("rr_byte_m%0d_b%0d", nmsg, bidx), bus.dbg_msg,
                        {4'(cur), 3'b000, 1'(bidx)});
                    bidx++;
                    if (bidx == 2)
                        nmsg++;
                end
                hs     = bus.req_valid & bus.req_ready;
                prev_g = bus.grant;
                tick();
                cnt = cnt ^ hs;
            end
            chk("rr_msgs_done", nmsg, 5);
        end
`else
        // Tag byte A3 held while full, then payload 55.
        drive(4'b1000, 4'b1000, 32'h5500_0000, 1'b0);
        #1;
        chk("tag_idle_grant", bus.grant, 4'h0);
        tick();
        bus.dbg_full = 1'b1;
        #1;
        chk("tag_full_wr",    bus.dbg_wr,    1'b0);
        chk("tag_full_ready", bus.req_ready, 4'h0);
        chk("tag_grant",      bus.grant,     4'b1000);
        tick();
        #1;
        chk("tag_full2_wr", bus.dbg_wr, 1'b0);
        tick();
        bus.dbg_full = 1'b0;
        #1;
        chk("tag_wr",    bus.dbg_wr,    1'b1);
        chk("tag_msg",   bus.dbg_msg,   8'hA3);
        chk("tag_ready", bus.req_ready, 4'h0);
        tick();
        chk("pay_wr",    bus.dbg_wr,    1'b1);
        chk("pay_msg",   bus.dbg_msg,   8'h55);
        chk("pay_ready", bus.req_ready, 4'b1000);
        tick();
        drive(4'h0, 4'h0, 32'h0, 1'b0);
        #1;
        chk("tag_end_grant", bus.grant, 4'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_dbg_arbiter.md
Name: uart_dbg_arbiter

Overview:
- Shares the single UART debug message channel (byte FIFO + transmitter) between NUM_SRC independent requesters.
- Each requester streams a multi-byte message using a valid/ready/last handshake.
- The arbiter grants whole messages round-robin, never interleaving bytes of two messages, and drives the debug channel's write strobe and byte while honouring its full flag.
- A stall timeout stops a dead requester from locking the channel.

Parameters:
- NUM_SRC, 4, number of requesters; legal range 2..16.
- TIMEOUT_CYCLES, 1024, consecutive starved cycles (granted source not valid) before the grant is revoked; legal range ≥2.
- SRC_W, $clog2(NUM_SRC), width of the source index (localparam).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_SRC  per-source byte valid.
- req_data  input  8*NUM_SRC  per-source byte; source i at bits [8i+7:8i].
- req_last  input  NUM_SRC  marks the final byte of a message; qualified by valid.
- req_ready  output  NUM_SRC  per-source byte accepted this cycle when valid&ready.
- dbg_wr  output  1  write strobe to the debug channel.
- dbg_msg  output  8  byte to the debug channel.
- dbg_full  input  1  debug channel full.
- grant  output  NUM_SRC  one-hot grant; all zero when idle.
- active_src  output  SRC_W  index of the granted source; holds its last value when idle.
- timeout_pulse  output  1  one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Reset (reset=0, asynchronous) puts the block in:
  - state IDLE, rr_ptr=0, grant=0, active_src=0, timer=0, timeout_pulse=0.
  - dbg_wr=0 and req_ready=0 immediately, because both are decoded from state.
- States: IDLE, TAG (exists only with SRC_TAG_EN), STREAM.
- IDLE:
  - If any req_valid is set, pick the first set bit searching from rr_ptr upward with wrap.
  - Register grant/active_src; go to TAG if enabled, else STREAM.
  - Arbitration costs exactly one cycle; no byte transfers in IDLE.
- STREAM, with g = active_src:
  - req_ready[g] = !dbg_full. All other req_ready are 0.
  - Transfer = req_valid[g] & req_ready[g].
  - dbg_wr = transfer (combinational).
  - dbg_msg = req_data[g] (combinational).
  - Latency from source byte to channel write is zero cycles.
- Transfer with req_last[g]=1:
  - Next state IDLE; grant cleared; rr_ptr = g+1, wrapping to 0 after NUM_SRC-1.
  - There is at least one idle cycle between messages.
- Sources must hold req_data/req_last stable while valid and not ready.
- dbg_full stall:
  - No transfer occurs and the timer is not advanced; a full sink never causes a timeout.
  - If dbg_full rises, the next cycle's ready falls with it; no write is ever issued while dbg_full=1.
- Timer:
  - In STREAM, increments on each cycle with !req_valid[g] & !dbg_full.
  - Clears on any transfer and on entry to STREAM.
  - When timer == TIMEOUT_CYCLES-1 and the source is still not valid: go to IDLE, timeout_pulse=1 for one cycle, rr_ptr = g+1.
  - Partial message bytes already written stay in the channel; no terminator is added.
- Fairness: a source asserting valid continuously is granted within NUM_SRC-1 messages.
- Boundary case: a source whose last byte coincides with a new request from the same source does not regain the grant if other sources are pending.
- Single-byte messages (valid&last on the first byte) are legal.
- Width rule: source indices above NUM_SRC-1 are never generated; rr_ptr wrap uses compare, not power-of-2 masking.

Optional Feature:
- Macro: UART_DBG_ARB_SRC_TAG_EN.
- Defined:
  - Each granted message is prefixed by one tag byte 8'hA0 | active_src, written in state TAG.
  - In TAG: dbg_wr = !dbg_full, req_ready=0, and the timer is held.
  - The state advances to STREAM on the cycle the tag is written.
  - Timeout does not apply in TAG.
- Not defined: the TAG state and tag logic are absent; IDLE goes directly to STREAM and the byte stream is payload only.

Test Plan:
- Single source 1 sends bytes 0x11,0x22,0x33(last), dbg_full=0 → three dbg_wr pulses with dbg_msg 0x11,0x22,0x33 on consecutive cycles; grant=4'b0010 throughout, then 0; rr_ptr=2.
- All 4 sources request 2-byte messages continuously from reset → grant order 0,1,2,3,0; bytes of different sources are never interleaved.
- Source 0 streaming, dbg_full held high for 10 cycles mid-message → no dbg_wr and req_ready[0]=0 during the stall; no timeout_pulse; the message completes intact afterwards.
- TIMEOUT_CYCLES=8: source 2 sends 1 byte, then drops valid → timeout_pulse on the 8th starved cycle; grant=0 next; pending source 3 is granted after one IDLE cycle.
- reset asserted low mid-message → dbg_wr, req_ready and grant are 0 in the same cycle; after release, arbitration restarts from source 0.
- With UART_DBG_ARB_SRC_TAG_EN, source 3 sends 0x55(last) → dbg_msg sequence 0xA3,0x55; with dbg_full high in TAG, the tag is held until dbg_full clears.
